// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with default-master parking; never splits a
// fixed-length burst or a locked sequence, and tracks address/data-phase owners.
//
// state  | meaning
// PARK   | no requests, default master granted
// GRANT  | a requester is granted, arbitration open
// BURST  | fixed-length burst in progress, grant held
// LOCKED | locked sequence in progress, grant held
module ahb_bus_arbiter #(
    parameter int MASTER_COUNT   = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MIDX_WIDTH     = $clog2(MASTER_COUNT)
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset,
    input  logic [MASTER_COUNT-1:0] i_hbusreq,
    input  logic [MASTER_COUNT-1:0] i_hlock,
    input  logic [1:0]              i_htrans,
    input  logic [2:0]              i_hburst,
    input  logic                    i_hready,
    output logic [MASTER_COUNT-1:0] o_hgrant,
    output logic [MIDX_WIDTH-1:0]   o_hmaster,
    output logic [MIDX_WIDTH-1:0]   o_hmaster_data,
    output logic                    o_hmastlock
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [MASTER_COUNT-1:0] GRANT_RESET =
        {{(MASTER_COUNT-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [MIDX_WIDTH-1:0] MIDX_DEFAULT = MIDX_WIDTH'(DEFAULT_MASTER);
    localparam logic [MIDX_WIDTH-1:0] PTR_RESET =
        MIDX_WIDTH'((DEFAULT_MASTER + 1) % MASTER_COUNT);

    typedef enum logic [1:0] {ST_PARK, ST_GRANT, ST_BURST, ST_LOCKED} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [MASTER_COUNT-1:0] r_hgrant;
    logic [MASTER_COUNT-1:0] w_hgrant_nxt;
    logic [MIDX_WIDTH-1:0]   r_hmaster;
    logic [MIDX_WIDTH-1:0]   r_hmaster_data;
    logic                    r_hmastlock;
    logic [3:0]              r_beat_cnt;
    logic [3:0]              w_beat_nxt;
    logic [MIDX_WIDTH-1:0]   r_rr_ptr;
    logic [MIDX_WIDTH-1:0]   w_rr_ptr_nxt;
    logic [MIDX_WIDTH-1:0]   w_grant_idx;
    logic [MIDX_WIDTH-1:0]   w_winner;
    logic [MIDX_WIDTH-1:0]   w_scan_idx;
    logic                    w_found;
    logic                    w_lock_hold;
    logic                    w_hold;
    int                      w_scan;

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (r_hgrant[i]) w_grant_idx = MIDX_WIDTH'(i);
        end
    end

    // Counter holds the beats still to come after the one being accepted.
    always_comb begin
        w_beat_nxt = r_beat_cnt;
        case (i_htrans)
            HTRANS_NONSEQ: begin
                case (i_hburst)
                    3'b010, 3'b011: w_beat_nxt = 4'd3;
                    3'b100, 3'b101: w_beat_nxt = 4'd7;
                    3'b110, 3'b111: w_beat_nxt = 4'd15;
                    default:        w_beat_nxt = 4'd0;
                endcase
            end
            HTRANS_SEQ: begin
                if (r_beat_cnt != 4'd0) w_beat_nxt = r_beat_cnt - 4'd1;
            end
            HTRANS_IDLE: w_beat_nxt = 4'd0;
            default:     w_beat_nxt = r_beat_cnt;
        endcase
    end

    assign w_lock_hold = r_hmastlock | i_hlock[r_hmaster];
    assign w_hold      = w_lock_hold | (w_beat_nxt != 4'd0);

    always_comb begin
        w_found    = 1'b0;
        w_winner   = MIDX_DEFAULT;
        w_scan     = 0;
        w_scan_idx = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            w_scan = int'(r_rr_ptr) + i;
            if (w_scan >= MASTER_COUNT) w_scan = w_scan - MASTER_COUNT;
            w_scan_idx = MIDX_WIDTH'(w_scan);
            if (!w_found && i_hbusreq[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_hgrant_nxt = r_hgrant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_state_nxt  = r_state;
        if (i_hready) begin
            if (!w_hold) begin
                w_hgrant_nxt = '0;
                if (w_found) begin
                    w_hgrant_nxt[w_winner] = 1'b1;
                    if (int'(w_winner) == MASTER_COUNT - 1) w_rr_ptr_nxt = '0;
                    else                                    w_rr_ptr_nxt = w_winner + MIDX_WIDTH'(1);
                end else begin
                    w_hgrant_nxt[DEFAULT_MASTER] = 1'b1;
                end
            end
            if (w_lock_hold)                w_state_nxt = ST_LOCKED;
            else if (w_beat_nxt != 4'd0)    w_state_nxt = ST_BURST;
            else if (|i_hbusreq)            w_state_nxt = ST_GRANT;
            else                            w_state_nxt = ST_PARK;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hreset) begin
            r_state        <= ST_PARK;
            r_hgrant       <= GRANT_RESET;
            r_hmaster      <= MIDX_DEFAULT;
            r_hmaster_data <= MIDX_DEFAULT;
            r_hmastlock    <= 1'b0;
            r_beat_cnt     <= 4'd0;
            r_rr_ptr       <= PTR_RESET;
        end else begin
            r_state <= w_state_nxt;
            if (i_hready) begin
                r_hgrant       <= w_hgrant_nxt;
                r_rr_ptr       <= w_rr_ptr_nxt;
                r_beat_cnt     <= w_beat_nxt;
                r_hmaster_data <= r_hmaster;
                r_hmaster      <= w_grant_idx;
                r_hmastlock    <= i_hlock[w_grant_idx];
            end
        end
    end

    assign o_hgrant       = r_hgrant;
    assign o_hmaster      = r_hmaster;
    assign o_hmaster_data = r_hmaster_data;
    assign o_hmastlock    = r_hmastlock;

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Multi-master AHB arbiter for the AHB interconnect. It turns the request system from one master plus slave decoder into a shared bus.
- Takes per-master bus requests and lock requests, issues one-hot grants, and tracks address-phase and data-phase bus ownership.
- Drives the address/control/write-data mux select in the interconnect.
- Never breaks a fixed-length burst or a locked sequence. Uses round-robin fairness and parks on a default master when the bus is idle.

Parameters:
- MASTER_COUNT, 3, number of requesting masters (2..8).
- DEFAULT_MASTER, 0, master granted when there are no requests (bus parking).
- MIDX_WIDTH, $clog2(MASTER_COUNT), width of the master index outputs.

Ports:
- i_hclk  in  1  bus clock; all timing is on its rising edge.
- i_hreset  in  1  reset, synchronous, active-low.
- i_hbusreq  in  MASTER_COUNT  per-master bus request.
- i_hlock  in  MASTER_COUNT  per-master locked-transfer request.
- i_htrans  in  2  muxed HTRANS of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- i_hburst  in  3  muxed HBURST of the current owner.
- i_hready  in  1  global HREADY from the interconnect.
- o_hgrant  out  MASTER_COUNT  one-hot grant, registered.
- o_hmaster  out  MIDX_WIDTH  address-phase owner index; selects the addr/ctrl mux.
- o_hmaster_data  out  MIDX_WIDTH  data-phase owner index; selects the hwdata mux.
- o_hmastlock  out  1  current address-phase transfer is locked.

Behaviour:
- Reset (i_hreset=0 at an edge):
  - o_hgrant = one-hot(DEFAULT_MASTER); o_hmaster = o_hmaster_data = DEFAULT_MASTER.
  - o_hmastlock = 0; beat counter = 0; round-robin pointer = DEFAULT_MASTER+1.
  - Reset mid-burst or mid-lock aborts unconditionally.
- All state updates only on edges where i_hready=1. When i_hready=0, every output and register holds.
- Ownership pipeline, at each hready edge:
  - o_hmaster_data <= o_hmaster.
  - o_hmaster <= index(o_hgrant).
  - o_hmastlock <= i_hlock[index(o_hgrant)].
  - Result: a new grant takes address ownership one hready cycle after o_hgrant changes, and data ownership one hready cycle after that.
- Beat counter (4-bit) tracks the current owner's fixed burst:
  - On an hready edge with i_htrans=NONSEQ, load beats-1: INCR4/WRAP4 -> 3, INCR8/WRAP8 -> 7, INCR16/WRAP16 -> 15, SINGLE/INCR -> 0.
  - Decrement on an hready edge with i_htrans=SEQ and counter>0.
  - BUSY and IDLE do not change the counter.
  - IDLE with counter>0 (early termination) clears the counter.
- Hold condition: hold = (next beat counter != 0) OR o_hmastlock OR i_hlock[o_hmaster].
  - While hold=1, o_hgrant is unchanged.
- Arbitration, at an hready edge with hold=0:
  - Scan i_hbusreq starting at the round-robin pointer, wrapping modulo MASTER_COUNT.
  - The first requester wins: o_hgrant <= one-hot(winner), pointer <= winner+1 (mod MASTER_COUNT).
  - No requests: o_hgrant <= one-hot(DEFAULT_MASTER); pointer unchanged.
  - Sole requester is the current owner: grant is kept (back-to-back transfers).
  - Undefined-length INCR bursts may be rearbitrated at any beat; the master must reissue NONSEQ.
- State machine (reported via internal state, debug only):
  - PARK: no requests, default master granted.
  - GRANT: a requester is granted and arbitration is open.
  - BURST: beat counter > 0.
  - LOCKED: hold is due to lock.
  - Transitions follow the conditions above. LOCKED has priority over BURST.
  - Leaving BURST or LOCKED always passes through one arbitration evaluation.
- o_hgrant is always exactly one-hot. Requests from masters at index >= MASTER_COUNT do not exist.
- Split/retry responses are not supported; HRESP errors do not affect arbitration.

Test Plan:
- Reset with all i_hbusreq=0 -> o_hgrant=001, o_hmaster=0, o_hmaster_data=0, o_hmastlock=0; state stays PARK for 10 cycles.
- Masters 0,1,2 request continuously, each doing SINGLE NONSEQ transfers with hready=1 -> grants rotate 0->1->2->0 (pointer order). o_hmaster trails o_hgrant by 1 cycle; o_hmaster_data trails by 2.
- Master 1 issues INCR8 (NONSEQ + 7 SEQ) while master 2 requests, with 2 BUSY cycles mid-burst -> o_hgrant stays 010 through all 8 accepted beats. Grant moves to 100 only at the edge accepting beat 8.
- Master 0 runs WRAP4 and the slave inserts 3 wait states (hready=0) on beat 2 -> all outputs frozen during the waits; the burst completes; grant moves after the 4th accepted beat.
- Master 2 asserts i_hlock for 3 SINGLE transfers while masters 0 and 1 request -> o_hmastlock=1 for those 3 address phases; grant stays 100 until the cycle after i_hlock drops.
- Assert i_hreset=0 mid-INCR16 owned by master 1 -> at that edge o_hgrant=001, beat counter=0, o_hmaster=0; on release, normal round-robin from master 1.
